// File: rtl/gpio_event_conditioner.sv
// GPIO button conditioner: 2-flop sync, debounce, press/release/long-press pulses.
// Define GPIO_ACTIVE_LOW_EN to treat a low pin level as pressed.
module gpio_event_conditioner #(
  parameter int N_CH        = 12,
  parameter int DEB_CYCLES  = 250000,
  parameter int LONG_CYCLES = 50000000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_gpio,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_long,
  output logic            o_any_press
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] LONG_MAX = HW'(LONG_CYCLES - 1);

  logic [N_CH-1:0] gpio_in;
  logic [N_CH-1:0] sync1_q, sync2_q;
  logic [N_CH-1:0] level_q, level_d;
  logic [N_CH-1:0] press_q, press_d;
  logic [N_CH-1:0] release_q, release_d;
  logic [N_CH-1:0] long_q, long_d;
  logic [N_CH-1:0] fired_q, fired_d;
  logic [DW-1:0]   deb_q  [N_CH];
  logic [DW-1:0]   deb_d  [N_CH];
  logic [HW-1:0]   hold_q [N_CH];
  logic [HW-1:0]   hold_d [N_CH];

`ifdef GPIO_ACTIVE_LOW_EN
  assign gpio_in = ~i_gpio;
`else
  assign gpio_in = i_gpio;
`endif

  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    fired_d   = fired_q;
    deb_d     = deb_q;
    hold_d    = hold_q;
    for (int i = 0; i < N_CH; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        deb_d[i] = '0;
      end else if (deb_q[i] == DEB_MAX) begin
        level_d[i] = sync2_q[i];
        deb_d[i]   = '0;
      end else begin
        deb_d[i] = deb_q[i] + 1'b1;
      end
      press_d[i]   = level_d[i] & ~level_q[i];
      release_d[i] = ~level_d[i] & level_q[i];
      // A falling level on the threshold cycle suppresses the long pulse
      if (!level_q[i] || !level_d[i]) begin
        hold_d[i]  = '0;
        fired_d[i] = 1'b0;
      end else if (!fired_q[i]) begin
        if (hold_q[i] == LONG_MAX) begin
          long_d[i]  = 1'b1;
          fired_d[i] = 1'b1;
        end else begin
          hold_d[i] = hold_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      fired_q   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        deb_q[i]  <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      sync1_q   <= gpio_in;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      fired_q   <= fired_d;
      deb_q     <= deb_d;
      hold_q    <= hold_d;
    end
  end

  assign o_level     = level_q;
  assign o_press     = press_q;
  assign o_release   = release_q;
  assign o_long      = long_q;
  assign o_any_press = |press_q;

endmodule

// File: tb/tb_gpio_event_conditioner.sv
// Self-checking bench for gpio_event_conditioner (DEB=4, LONG=10, 12 channels).
// Vector table, directed corner sequences and random stimulus against a model.
module tb_gpio_event_conditioner;

  localparam int NC   = 12;
  localparam int DEB  = 4;
  localparam int LONG = 10;
`ifdef GPIO_ACTIVE_LOW_EN
  localparam logic [NC-1:0] INV = 12'hFFF;
`else
  localparam logic [NC-1:0] INV = 12'h000;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NC-1:0] i_gpio = INV;
  logic [NC-1:0] o_level, o_press, o_release, o_long;
  logic          o_any_press;

  int checks = 0;
  int errors = 0;

  gpio_event_conditioner #(
    .N_CH(NC), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_gpio(i_gpio),
    .o_level(o_level), .o_press(o_press), .o_release(o_release),
    .o_long(o_long), .o_any_press(o_any_press)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a level flips once the last DEB synchronised samples
  // all disagree with it; long fires LONG edges after the rising edge.
  logic [NC-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0;
  logic [NC-1:0] m_press = '0, m_rel = '0, m_long = '0;
  bit            hist [NC][$];
  int            rise_at [NC];
  int            ecount = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0;
      m_press = '0; m_rel = '0; m_long = '0;
      ecount = 0;
      for (int c = 0; c < NC; c++) begin
        hist[c].delete();
        rise_at[c] = 0;
      end
    end else begin
      logic [NC-1:0] nl;
      bit            all_diff;
      nl = m_lvl;
      for (int c = 0; c < NC; c++) begin
        hist[c].push_back(m_s2[c]);
        if (hist[c].size() > DEB) void'(hist[c].pop_front());
        all_diff = (hist[c].size() == DEB);
        foreach (hist[c][k]) if (hist[c][k] == m_lvl[c]) all_diff = 0;
        if (all_diff) begin
          nl[c] = ~m_lvl[c];
          hist[c].delete();
        end
      end
      m_press = nl & ~m_lvl;
      m_rel   = ~nl & m_lvl;
      for (int c = 0; c < NC; c++) begin
        if (m_press[c]) rise_at[c] = ecount;
        m_long[c] = nl[c] && m_lvl[c] && (ecount - rise_at[c] == LONG);
      end
      m_lvl = nl;
      m_s2  = m_s1;
      m_s1  = i_gpio ^ INV;
      ecount++;
    end
  end

  int pcnt [NC];
  int rcnt [NC];
  int lcnt [NC];
  initial for (int c = 0; c < NC; c++) begin
    pcnt[c] = 0; rcnt[c] = 0; lcnt[c] = 0;
  end

  always @(negedge clk) begin
    chk("model_level", 32'(o_level), 32'(m_lvl));
    chk("model_press", 32'(o_press), 32'(m_press));
    chk("model_release", 32'(o_release), 32'(m_rel));
    chk("model_long", 32'(o_long), 32'(m_long));
    chk("model_any", 32'(o_any_press), 32'(|m_press));
    for (int c = 0; c < NC; c++) begin
      pcnt[c] += int'(o_press[c]);
      rcnt[c] += int'(o_release[c]);
      lcnt[c] += int'(o_long[c]);
    end
  end

  task automatic drv(input logic [NC-1:0] v);
    @(negedge clk);
    i_gpio = v ^ INV;
  endtask

  task automatic wait_lvl(input int ch, input logic v, output int n);
    n = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (o_level[ch] == v) begin n = k; break; end
    end
  endtask

  task automatic wait_bit(input int sel, input int ch, output int n);
    n = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if ((sel == 0 && o_press[ch]) || (sel == 1 && o_long[ch])) begin
        n = k; break;
      end
    end
  endtask

  typedef struct {
    logic [NC-1:0] gpio;
    int            hold;
    logic [NC-1:0] exp_level;
  } vec_t;

  vec_t vt [6];
  int   n, p0, l0, r0;

  initial begin
    vt[0] = '{12'h000, 10, 12'h000};
    vt[1] = '{12'h800, 20, 12'h800};
    vt[2] = '{12'h005, 10, 12'h005};
    vt[3] = '{12'h00F, 3,  12'h005};
    vt[4] = '{12'h00F, 10, 12'h00F};
    vt[5] = '{12'h000, 10, 12'h000};

    repeat (3) @(negedge clk);
    chk("reset_outputs",
        32'({o_level, o_press, o_release, o_long, o_any_press}), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vt[i]) begin
      drv(vt[i].gpio);
      repeat (vt[i].hold) @(negedge clk);
      chk($sformatf("vec%0d_level", i), 32'(o_level), 32'(vt[i].exp_level));
    end

    // clean press on channel 11
    p0 = pcnt[11];
    drv(12'h800);
    wait_lvl(11, 1'b1, n);
    chk("clean_latency", 32'(n), 32'd6);
    chk("clean_press", 32'(o_press), 32'h800);
    chk("clean_any", 32'(o_any_press), 32'd1);
    repeat (18) @(negedge clk);
    chk("clean_press_once", 32'(pcnt[11] - p0), 32'd1);
    drv(12'h000);
    repeat (10) @(negedge clk);

    // bounce on channel 9
    p0 = pcnt[9]; r0 = rcnt[9];
    for (int k = 0; k < 5; k++) begin
      drv(12'h200);
      repeat (2) @(negedge clk);
      drv(12'h000);
    end
    repeat (12) @(negedge clk);
    chk("bounce_press", 32'(pcnt[9] - p0), 32'd0);
    chk("bounce_release", 32'(rcnt[9] - r0), 32'd0);
    chk("bounce_level", 32'(o_level), 32'd0);

    // long press on channel 8
    p0 = pcnt[8]; l0 = lcnt[8]; r0 = rcnt[8];
    drv(12'h100);
    wait_lvl(8, 1'b1, n);
    chk("long_rise", 32'(n), 32'd6);
    wait_bit(1, 8, n);
    chk("long_delay", 32'(n), 32'(LONG));
    repeat (24) @(negedge clk);
    drv(12'h000);
    wait_lvl(8, 1'b0, n);
    chk("long_release_lat", 32'(n), 32'd6);
    repeat (4) @(negedge clk);
    chk("long_press_cnt", 32'(pcnt[8] - p0), 32'd1);
    chk("long_long_cnt", 32'(lcnt[8] - l0), 32'd1);
    chk("long_rel_cnt", 32'(rcnt[8] - r0), 32'd1);

    // simultaneous channels
    drv(12'h005);
    n = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (o_press != 0) begin n = k; break; end
    end
    chk("simul_lat", 32'(n), 32'd6);
    chk("simul_press", 32'(o_press), 32'h005);
    chk("simul_level", 32'(o_level[3:0]), 32'h5);
    drv(12'h000);
    repeat (10) @(negedge clk);

    // reset two cycles after level rose on channel 10
    drv(12'h400);
    wait_lvl(10, 1'b1, n);
    repeat (2) @(negedge clk);
    rst = 1'b1; #1;
    chk("rst1_zero", 32'({o_level, o_press, o_release, o_long}), 32'd0);
    repeat (2) @(negedge clk);
    p0 = pcnt[10];
    rst = 1'b0;
    wait_bit(0, 10, n);
    chk("rst1_press_lat", 32'(n), 32'd6);
    repeat (20) @(negedge clk);
    chk("rst1_press_once", 32'(pcnt[10] - p0), 32'd1);
    drv(12'h000);
    repeat (10) @(negedge clk);

    // reset while the debounce counter sits at 2
    drv(12'h400);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1; #1;
    chk("rst2_zero", 32'({o_level, o_press, o_release, o_long}), 32'd0);
    repeat (2) @(negedge clk);
    p0 = pcnt[10];
    rst = 1'b0;
    wait_bit(0, 10, n);
    chk("rst2_press_lat", 32'(n), 32'd6);
    repeat (20) @(negedge clk);
    chk("rst2_press_once", 32'(pcnt[10] - p0), 32'd1);
    drv(12'h000);
    repeat (10) @(negedge clk);

    // random stimulus, checked every cycle against the model
    for (int s = 0; s < 60; s++) begin
      drv(NC'($urandom));
      repeat ($urandom_range(1, 20)) @(negedge clk);
      if ($urandom_range(0, 14) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    drv(12'h000);
    repeat (20) @(negedge clk);
    chk("final_level", 32'(o_level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_event_conditioner.md
Name: gpio_event_conditioner

Overview:
- Upstream stage between the raw GPIO button header and the control core's state machine. The control core consumes REC/PLAY/STOP/MIX and chunk-select bits as levels.
- Per channel, the block synchronises the raw asynchronous input, debounces it, and produces:
  - a clean level;
  - one-cycle press and release pulses;
  - a one-shot long-press pulse.
- This removes bounce-induced double transitions and metastability before state decisions are made.

Parameters:
- N_CH, 12, number of GPIO channels conditioned (bit i of every vector port = channel i).
- DEB_CYCLES, 250000, consecutive stable cycles required to accept a level change (5 ms at 50 MHz); legal range ≥2.
- LONG_CYCLES, 50000000, cycles a debounced level must stay 1 before o_long fires (1 s at 50 MHz); legal range ≥2.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_gpio  input  N_CH  raw asynchronous button inputs.
- o_level  output  N_CH  debounced level per channel.
- o_press  output  N_CH  one-cycle pulse on the debounced 0→1 transition.
- o_release  output  N_CH  one-cycle pulse on the debounced 1→0 transition.
- o_long  output  N_CH  one-cycle pulse when the level has been 1 for LONG_CYCLES cycles.
- o_any_press  output  1  OR-reduction of o_press, same cycle.

Behaviour:
- Reset: all outputs 0; synchroniser flops, debounce counters, hold counters and long-fired flags all 0.
  - Asynchronous reset mid-operation aborts all counts.
  - After reset is released, a channel held high re-qualifies from scratch and yields exactly one press.
- Synchroniser: 2-flop chain per channel, s[i] = second flop.
- Debounce counter per channel, width $clog2(DEB_CYCLES). Each cycle:
  - s[i]==o_level[i]: counter ← 0.
  - s[i]!=o_level[i] and counter==DEB_CYCLES-1: o_level[i] ← s[i], counter ← 0.
  - Otherwise: counter ← counter+1.
- Latency: a raw edge that stays stable reaches o_level exactly DEB_CYCLES+2 clock edges after the first edge that samples the new value.
- Glitch rejection: any glitch shorter than DEB_CYCLES cycles (as seen at s) produces no output activity.
- Press and release pulses:
  - o_press[i] and o_release[i] are registered and asserted in the same cycle o_level[i] changes; width exactly 1 cycle.
  - Press and release on one channel can never coincide.
  - Different channels are fully independent; simultaneous events on several channels assert several bits in the same cycle.
- Long-press:
  - Hold counter per channel, width $clog2(LONG_CYCLES+1).
  - While o_level[i]==1 and the fired flag is 0, the counter increments each cycle.
  - When the counter reaches LONG_CYCLES-1, o_long[i] pulses for 1 cycle and the fired flag is set. Net effect: o_long is asserted in the cycle when o_level has been 1 for LONG_CYCLES cycles.
  - While the fired flag is set, the counter holds, so there is exactly one o_long per press regardless of hold length.
  - When o_level[i]==0, the counter and fired flag clear.
  - A release on the same cycle the counter would reach the threshold takes priority: no o_long.
- o_any_press: combinational OR of the registered o_press bits.
- No handshake: the consumer must sample the pulses on every cycle.

Optional Feature:
- Macro: GPIO_ACTIVE_LOW_EN.
- Defined: i_gpio is inverted before the synchroniser, so the physical low level reads as pressed (1). After reset, a header idling high produces no press event because the inverted value (0) equals the reset level.
- Undefined: i_gpio is used as-is (active-high), and the behaviour is as specified above.

Test Plan:
Bench parameters for all scenarios: DEB_CYCLES=4, LONG_CYCLES=10, N_CH=12, macro undefined unless stated.
- Clean press: i_gpio[11] 0→1 held 20 cycles → o_level[11] rises 6 edges after the first sampling edge; o_press[11]=1 for exactly 1 cycle; o_any_press mirrors it; no other bits toggle.
- Bounce rejection: i_gpio[9] high for 3 cycles, low for 1 cycle, repeated 5 times, then low → o_level, o_press and o_release stay 0 throughout.
- Long press: i_gpio[8] held high 40 cycles then low → one o_press; one o_long exactly 10 cycles after o_level rises; no second o_long; one o_release 6 edges after the fall.
- Simultaneous channels: i_gpio[3:0] 0000→0101 in one cycle → o_press = 12'h005 in a single cycle; o_level[3:0] = 0101.
- Reset mid-debounce: i_gpio[10] high, i_rst pulsed 2 cycles after o_level[10] rose (and at counter=2 in a second run) → all outputs 0 immediately; after release, o_press[10] fires once, 6 edges later.
- GPIO_ACTIVE_LOW_EN defined: i_gpio=12'hFFF from reset → no events; drive bit 10 low → o_press[10] after 6 edges.
